// File: rtl/uart_apb_core.sv
// uart_apb_core: 8N1 UART receive front end plus a single-transfer APB master
// driving an internal four-register APB slave, with the bus exported for monitoring.
// Optional feature macro: APB_WAIT_STATE_EN (slave inserts one wait state per transfer).
module uart_apb_core #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx,
   output logic [7:0]        rx_data,
   output logic              rx_data_valid,
   input  logic              start,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              write_en,
   output logic [DATA_W-1:0] rdata,
   output logic              done,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   output logic              PWRITE,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PREADY,
   output logic [DATA_W-1:0] PRDATA
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;
   localparam int unsigned HALF  = CLKS_PER_BIT / 2;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS} apb_state_t;

   rx_state_t        rx_state, rx_state_nx;
   logic             rx_meta, rx_sync, rx_prev;
   logic [CNT_W-1:0] rx_cnt, rx_cnt_nx;
   logic [2:0]       rx_bit, rx_bit_nx;
   logic [7:0]       rx_shift, rx_shift_nx, rx_data_nx;
   logic             rx_valid_nx;

   apb_state_t       apb_state, apb_state_nx;
   logic             xfer_done_c;
   logic [DATA_W-1:0] slv_reg [4];

   // Receiver registers; the line synchroniser idles high so reset never looks like a start bit
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_meta       <= 1'b1;
         rx_sync       <= 1'b1;
         rx_prev       <= 1'b1;
         rx_state      <= RX_IDLE;
         rx_cnt        <= '0;
         rx_bit        <= '0;
         rx_shift      <= '0;
         rx_data       <= '0;
         rx_data_valid <= 1'b0;
      end else begin
         rx_meta       <= rx;
         rx_sync       <= rx_meta;
         rx_prev       <= rx_sync;
         rx_state      <= rx_state_nx;
         rx_cnt        <= rx_cnt_nx;
         rx_bit        <= rx_bit_nx;
         rx_shift      <= rx_shift_nx;
         rx_data       <= rx_data_nx;
         rx_data_valid <= rx_valid_nx;
      end
   end

   // Receiver next state: mid-bit check of start, then 9 full-bit-spaced samples
   always_comb begin
      rx_state_nx = rx_state;
      rx_cnt_nx   = rx_cnt + CNT_W'(1);
      rx_bit_nx   = rx_bit;
      rx_shift_nx = rx_shift;
      rx_data_nx  = rx_data;
      rx_valid_nx = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            rx_cnt_nx = '0;
            rx_bit_nx = '0;
            if (rx_prev && !rx_sync) rx_state_nx = RX_START;
         end
         RX_START: begin
            if (rx_cnt == CNT_W'(HALF - 1)) begin
               rx_cnt_nx   = '0;
               rx_state_nx = rx_sync ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
               rx_cnt_nx   = '0;
               rx_shift_nx = {rx_sync, rx_shift[7:1]};
               rx_bit_nx   = rx_bit + 3'd1;
               if (rx_bit == 3'd7) rx_state_nx = RX_STOP;
            end
         end
         RX_STOP: begin
            if (rx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
               rx_cnt_nx   = '0;
               rx_state_nx = RX_IDLE;
               if (rx_sync) begin
                  rx_data_nx  = rx_shift;
                  rx_valid_nx = 1'b1;
               end
            end
         end
         default: rx_state_nx = RX_IDLE;
      endcase
   end

   assign xfer_done_c = (apb_state == APB_ACCESS) && PREADY;

   // APB master next state; start only matters in IDLE
   always_comb begin
      apb_state_nx = apb_state;
      case (apb_state)
         APB_IDLE:   if (start) apb_state_nx = APB_SETUP;
         APB_SETUP:  apb_state_nx = APB_ACCESS;
         APB_ACCESS: if (PREADY) apb_state_nx = APB_IDLE;
         default:    apb_state_nx = APB_IDLE;
      endcase
   end

   // APB master state and registered bus/handshake outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         apb_state <= APB_IDLE;
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         PADDR     <= '0;
         PWDATA    <= '0;
         PWRITE    <= 1'b0;
         done      <= 1'b0;
         rdata     <= '0;
      end else begin
         apb_state <= apb_state_nx;
         PSEL      <= (apb_state_nx != APB_IDLE);
         PENABLE   <= (apb_state_nx == APB_ACCESS);
         done      <= xfer_done_c;
         if (apb_state == APB_IDLE && start) begin
            PADDR  <= addr;
            PWDATA <= wdata;
            PWRITE <= write_en;
         end
         if (xfer_done_c && !PWRITE) rdata <= PRDATA;
      end
   end

`ifdef APB_WAIT_STATE_EN
   logic wait_q;

   // Ready only on the second ACCESS cycle of each transfer
   always_ff @(posedge clk) begin
      if (!rst_n) wait_q <= 1'b0;
      else        wait_q <= PSEL && PENABLE && !PREADY;
   end

   assign PREADY = PSEL && PENABLE && wait_q;
`else
   assign PREADY = PSEL && PENABLE;
`endif

   // Slave register file, indexed by the low two address bits
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) slv_reg[i] <= '0;
      end else if (PSEL && PENABLE && PREADY && PWRITE) begin
         slv_reg[PADDR[1:0]] <= PWDATA;
      end
   end

   assign PRDATA = PSEL ? slv_reg[PADDR[1:0]] : '0;

endmodule

// File: tb/tb_uart_apb_core.sv
// Testbench for uart_apb_core: random APB transfers and UART frames against a
// behavioural register/byte model. Honours APB_WAIT_STATE_EN when defined.
module tb_uart_apb_core;
   localparam int unsigned CPB = 16;
   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int          LAT = 2 + CPB / 2 + 9 * CPB;

   logic          clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
   logic          start = 1'b0, write_en = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [DW-1:0] wdata = '0;
   logic [7:0]    rx_data;
   logic          rx_data_valid, done, PWRITE, PSEL, PENABLE, PREADY;
   logic [DW-1:0] rdata, PWDATA, PRDATA;
   logic [AW-1:0] PADDR;

   uart_apb_core #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .rx(rx), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
      .start(start), .addr(addr), .wdata(wdata), .write_en(write_en), .rdata(rdata), .done(done),
      .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
      .PREADY(PREADY), .PRDATA(PRDATA));

   always #5 clk = ~clk;

   int          checks = 0, errors = 0;
   int unsigned cyc = 0, fall_cyc = 0;
   logic [DW-1:0] m_reg [4];
   logic [DW-1:0] m_rdata = '0;
   logic [7:0]    m_rx_last = '0;
   logic [7:0]    exp_q[$], got_q[$];
   int            lat_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Capture every received byte and its latency from the start-bit fall
   always @(negedge clk) begin
      if (rst_n && rx_data_valid) begin
         got_q.push_back(rx_data);
         lat_q.push_back(int'(cyc - fall_cyc));
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One APB transfer with cycle-exact bus checks; optional start poke during ACCESS
   task automatic apb_xfer(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic we,
                           input bit poke);
      logic [1:0] idx;
      idx = a[1:0];
      @(negedge clk);
      start = 1'b1; addr = a; wdata = d; write_en = we;
      @(posedge clk); #1;
      start = 1'b0; addr = $urandom; wdata = $urandom; write_en = ~we;
      check("setup_bus", {PSEL, PENABLE}, 2'b10);
      check("setup_paddr", PADDR, a);
      @(posedge clk); #1;
      if (poke) start = 1'b1;
`ifdef APB_WAIT_STATE_EN
      check("access_wait", {PSEL, PENABLE, PREADY}, 3'b110);
      @(posedge clk); #1;
`endif
      check("access_bus", {PSEL, PENABLE, PREADY}, 3'b111);
      if (we) check("access_pwdata", {PWRITE, PWDATA}, {1'b1, d});
      else    check("access_prdata", PRDATA, m_reg[idx]);
      @(posedge clk); #1;
      start = 1'b0;
      if (we) m_reg[idx] = d;
      else    m_rdata = m_reg[idx];
      check("done_cycle", {done, PSEL}, 2'b10);
      check("rdata", rdata, m_rdata);
      @(posedge clk); #1;
      check("after_done", {done, PSEL}, 2'b00);
   endtask

   // Drive one 8N1 frame; called on a falling clock edge, returns on one
   task automatic send_frame(input logic [7:0] b, input logic stop);
      rx = 1'b0; fall_cyc = cyc;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      if (stop) begin
         exp_q.push_back(b);
         m_rx_last = b;
      end
   endtask

   // Compare received bytes against the model and drain both queues
   task automatic rx_check(input string tag);
      int lat;
      repeat (2 * CPB) @(negedge clk);
      check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         check({tag, "_byte"}, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
         lat = lat_q.pop_front();
         check({tag, "_latency_ok"}, 64'(lat >= LAT - 1 && lat <= LAT + 2), 64'(1));
      end
      got_q.delete(); exp_q.delete(); lat_q.delete();
      check({tag, "_hold"}, rx_data, m_rx_last);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) m_reg[i] = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ctrl", {PSEL, PENABLE, PREADY, done, PWRITE, rx_data_valid}, 6'b0);
      check("rst_rdata", rdata, 0);
      check("rst_paddr", {PADDR, PWDATA}, 0);
      check("rst_rx", {rx_data, PRDATA}, 0);
      @(negedge clk); rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_psel", {PSEL, done}, 2'b00);

      apb_xfer(32'd2, 32'h15, 1'b1, 1'b0);
      apb_xfer(32'd2, 32'h0, 1'b0, 1'b0);
      check("read_back_0x15", rdata, 32'h15);
      apb_xfer(32'h6, 32'h0, 1'b0, 1'b0);
      apb_xfer(32'd1, 32'h0, 1'b0, 1'b0);
      apb_xfer(32'h1234_5673, 32'hDEAD_BEEF, 1'b1, 1'b1);
      apb_xfer(32'd3, 32'h0, 1'b0, 1'b1);

      @(negedge clk);
      send_frame(8'hA5, 1'b1);
      send_frame(8'h3C, 1'b1);
      rx_check("rx_pair");
      send_frame(8'h5A, 1'b0);
      rx_check("rx_framing");
      rx = 1'b0; repeat (4) @(negedge clk); rx = 1'b1;
      repeat (CPB) @(negedge clk);
      rx_check("rx_glitch");

      for (int n = 0; n < 24; n++)
         apb_xfer($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int n = 0; n < 6; n++) send_frame(8'($urandom), 1'b1);
      rx_check("rx_random");

      // Reset while a transfer is in SETUP
      @(negedge clk);
      start = 1'b1; addr = 32'd2; wdata = 32'hAA; write_en = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk); rst_n = 1'b0;
      @(posedge clk); #1;
      check("rst_mid_psel", {PSEL, PENABLE}, 2'b00);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_no_done", done, 1'b0);
      for (int i = 0; i < 4; i++) m_reg[i] = '0;
      m_rdata = '0; m_rx_last = '0;
      apb_xfer(32'd2, 32'h0, 1'b0, 1'b0);

      // Reset part way through a byte
      @(negedge clk);
      rx = 1'b0; repeat (3 * CPB) @(negedge clk);
      rst_n = 1'b0; @(negedge clk); rx = 1'b1; rst_n = 1'b1;
      repeat (10 * CPB) @(negedge clk);
      rx_check("rx_reset_mid");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
